// File: rtl/tcdm_shim_arbiter.sv
// tcdm_shim_arbiter: round-robin sharing of one TCDM shim data port between NumReq requesters,
// with read IDs remapped onto a meta-ID table so out-of-order responses route back to their owner.
module tcdm_shim_arbiter #(
    parameter int NumReq              = 2,
    parameter int AddrWidth           = 32,
    parameter int DataWidth           = 32,
    parameter int MaxOutStandingReads = 8,
    parameter int ReqIdWidth          = 3,
    localparam int StrbWidth          = DataWidth / 8,
    localparam int MetaIdWidth        = (MaxOutStandingReads > 1) ? $clog2(MaxOutStandingReads) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumReq-1:0][AddrWidth-1:0]      req_qaddr_i,
    input  logic [NumReq-1:0]                     req_qwrite_i,
    input  logic [NumReq-1:0][3:0]                req_qamo_i,
    input  logic [NumReq-1:0][DataWidth-1:0]      req_qdata_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]      req_qstrb_i,
    input  logic [NumReq-1:0][ReqIdWidth-1:0]     req_qid_i,
    input  logic [NumReq-1:0]                     req_qlrwait_i,
    input  logic [NumReq-1:0]                     req_qvalid_i,
    output logic [NumReq-1:0]                     req_qready_o,
    output logic [NumReq-1:0][DataWidth-1:0]      req_pdata_o,
    output logic [NumReq-1:0]                     req_perror_o,
    output logic [NumReq-1:0][ReqIdWidth-1:0]     req_pid_o,
    output logic [NumReq-1:0]                     req_plrwait_o,
    output logic [NumReq-1:0]                     req_pvalid_o,
    input  logic [NumReq-1:0]                     req_pready_i,
    output logic [AddrWidth-1:0]                  data_qaddr_o,
    output logic                                  data_qwrite_o,
    output logic [3:0]                            data_qamo_o,
    output logic [DataWidth-1:0]                  data_qdata_o,
    output logic [StrbWidth-1:0]                  data_qstrb_o,
    output logic                                  data_qlrwait_o,
    output logic [MetaIdWidth-1:0]                data_qid_o,
    output logic                                  data_qvalid_o,
    input  logic                                  data_qready_i,
    input  logic [DataWidth-1:0]                  data_pdata_i,
    input  logic                                  data_perror_i,
    input  logic [MetaIdWidth-1:0]                data_pid_i,
    input  logic                                  data_plrwait_i,
    input  logic                                  data_pvalid_i,
    output logic                                  data_pready_o
);
    localparam int GntWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    typedef logic [GntWidth-1:0] gnt_t;
    typedef logic [MetaIdWidth-1:0] meta_t;

    if (AddrWidth != 32) begin : g_addr_chk
        $fatal(1, "tcdm_shim_arbiter: only AddrWidth = 32 is supported");
    end
    if (DataWidth != 32) begin : g_data_chk
        $fatal(1, "tcdm_shim_arbiter: only DataWidth = 32 is supported");
    end
    if (NumReq < 2) begin : g_req_chk
        $fatal(1, "tcdm_shim_arbiter: NumReq must be at least 2");
    end

    logic [MaxOutStandingReads-1:0]                 valid_q, valid_d;
    gnt_t [MaxOutStandingReads-1:0]                 owner_q, owner_d;
    logic [MaxOutStandingReads-1:0][ReqIdWidth-1:0] orig_id_q, orig_id_d;
    gnt_t                                           rr_ptr_q, rr_ptr_d;
    gnt_t                                           lock_idx_q, lock_idx_d;
    meta_t                                          lock_mid_q, lock_mid_d;
    logic                                           lock_q, lock_d;

    logic              full;
    meta_t             free_idx;
    logic [NumReq-1:0] eligible;
    gnt_t              gnt;
    logic              req_hs;
    logic              rsp_hit;
    logic              rsp_hs;
    gnt_t              rsp_owner;

    assign full = &valid_q;

    always_comb begin
        free_idx = '0;
        for (int i = MaxOutStandingReads - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = meta_t'(i);
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++)
            eligible[i] = req_qvalid_i[i] & (req_qwrite_i[i] | ~full);
    end

    // First eligible requester from rr_ptr upwards; a pending lock overrides the scan.
    always_comb begin
        logic found;
        gnt   = rr_ptr_q;
        found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NumReq) j -= NumReq;
            if (!found && eligible[j]) begin
                gnt   = gnt_t'(j);
                found = 1'b1;
            end
        end
        if (lock_q) gnt = lock_idx_q;
    end

    assign data_qvalid_o  = eligible[gnt];
    assign data_qaddr_o   = req_qaddr_i[gnt];
    assign data_qwrite_o  = req_qwrite_i[gnt];
    assign data_qamo_o    = req_qamo_i[gnt];
    assign data_qdata_o   = req_qdata_i[gnt];
    assign data_qstrb_o   = req_qstrb_i[gnt];
    assign data_qlrwait_o = req_qlrwait_i[gnt];
    // The meta ID is frozen while locked so a response-side free cannot move it under the offer.
    assign data_qid_o     = req_qwrite_i[gnt] ? '0 : (lock_q ? lock_mid_q : free_idx);
    assign req_hs         = data_qvalid_o & data_qready_i;

    always_comb begin
        req_qready_o      = '0;
        req_qready_o[gnt] = data_qready_i & eligible[gnt];
    end

    assign rsp_hit       = valid_q[data_pid_i];
    assign rsp_owner     = owner_q[data_pid_i];
    assign data_pready_o = rsp_hit ? req_pready_i[rsp_owner] : data_pvalid_i;
    assign rsp_hs        = data_pvalid_i & data_pready_o & rsp_hit;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_pvalid_o[i]  = data_pvalid_i & rsp_hit & (rsp_owner == gnt_t'(i));
            req_pdata_o[i]   = data_pdata_i;
            req_perror_o[i]  = data_perror_i;
            req_plrwait_o[i] = data_plrwait_i;
            req_pid_o[i]     = orig_id_q[data_pid_i];
        end
    end

    always_comb begin
        valid_d    = valid_q;
        owner_d    = owner_q;
        orig_id_d  = orig_id_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = data_qvalid_o & ~data_qready_i;
        lock_idx_d = gnt;
        lock_mid_d = data_qid_o;
        if (rsp_hs) valid_d[data_pid_i] = 1'b0;
        if (req_hs) begin
            rr_ptr_d = (int'(gnt) == NumReq - 1) ? '0 : gnt_t'(gnt + 1'b1);
            if (!req_qwrite_i[gnt]) begin
                valid_d[data_qid_o]   = 1'b1;
                owner_d[data_qid_o]   = gnt;
                orig_id_d[data_qid_o] = req_qid_i[gnt];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            owner_q    <= '0;
            orig_id_q  <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            lock_mid_q <= '0;
        end else begin
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            orig_id_q  <= orig_id_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            lock_mid_q <= lock_mid_d;
        end
    end

    a_rsp_alloc : assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_pvalid_i |-> valid_q[data_pid_i])
        else $error("tcdm_shim_arbiter: response for unallocated meta ID %0d", data_pid_i);

endmodule

// File: tb/tb_tcdm_shim_arbiter.sv
// tb_tcdm_shim_arbiter: directed stimulus with a queue scoreboard; a negedge monitor
// checks every shim-side request handshake and every requester-side response handshake.
module tb_tcdm_shim_arbiter;
    localparam int NR = 2;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [NR-1:0][31:0] req_qaddr_i;
    logic [NR-1:0]       req_qwrite_i;
    logic [NR-1:0][3:0]  req_qamo_i;
    logic [NR-1:0][31:0] req_qdata_i;
    logic [NR-1:0][3:0]  req_qstrb_i;
    logic [NR-1:0][2:0]  req_qid_i;
    logic [NR-1:0]       req_qlrwait_i;
    logic [NR-1:0]       req_qvalid_i;
    logic [NR-1:0]       req_qready_o;
    logic [NR-1:0][31:0] req_pdata_o;
    logic [NR-1:0]       req_perror_o;
    logic [NR-1:0][2:0]  req_pid_o;
    logic [NR-1:0]       req_plrwait_o;
    logic [NR-1:0]       req_pvalid_o;
    logic [NR-1:0]       req_pready_i;
    logic [31:0]         data_qaddr_o;
    logic                data_qwrite_o;
    logic [3:0]          data_qamo_o;
    logic [31:0]         data_qdata_o;
    logic [3:0]          data_qstrb_o;
    logic                data_qlrwait_o;
    logic [2:0]          data_qid_o;
    logic                data_qvalid_o;
    logic                data_qready_i;
    logic [31:0]         data_pdata_i;
    logic                data_perror_i;
    logic [2:0]          data_pid_i;
    logic                data_plrwait_i;
    logic                data_pvalid_i;
    logic                data_pready_o;

    tcdm_shim_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_qaddr_i(req_qaddr_i), .req_qwrite_i(req_qwrite_i), .req_qamo_i(req_qamo_i),
        .req_qdata_i(req_qdata_i), .req_qstrb_i(req_qstrb_i), .req_qid_i(req_qid_i),
        .req_qlrwait_i(req_qlrwait_i), .req_qvalid_i(req_qvalid_i), .req_qready_o(req_qready_o),
        .req_pdata_o(req_pdata_o), .req_perror_o(req_perror_o), .req_pid_o(req_pid_o),
        .req_plrwait_o(req_plrwait_o), .req_pvalid_o(req_pvalid_o), .req_pready_i(req_pready_i),
        .data_qaddr_o(data_qaddr_o), .data_qwrite_o(data_qwrite_o), .data_qamo_o(data_qamo_o),
        .data_qdata_o(data_qdata_o), .data_qstrb_o(data_qstrb_o), .data_qlrwait_o(data_qlrwait_o),
        .data_qid_o(data_qid_o), .data_qvalid_o(data_qvalid_o), .data_qready_i(data_qready_i),
        .data_pdata_i(data_pdata_i), .data_perror_i(data_perror_i), .data_pid_i(data_pid_i),
        .data_plrwait_i(data_plrwait_i), .data_pvalid_i(data_pvalid_i), .data_pready_o(data_pready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {int r; logic w; logic [31:0] a; logic [31:0] d; logic [2:0] m;} qx_t;
    typedef struct {int r; logic [31:0] d; logic [2:0] p;} px_t;
    qx_t qexp[$];
    px_t pexp[$];
    qx_t qe;
    px_t pe;
    int tests = 0;
    int fails = 0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(int r, logic [31:0] a, logic [2:0] id);
        req_qvalid_i[r] = 1'b1;
        req_qwrite_i[r] = 1'b0;
        req_qaddr_i[r]  = a;
        req_qid_i[r]    = id;
        req_qdata_i[r]  = '0;
    endtask

    task automatic wr(int r, logic [31:0] a, logic [31:0] d);
        req_qvalid_i[r] = 1'b1;
        req_qwrite_i[r] = 1'b1;
        req_qaddr_i[r]  = a;
        req_qdata_i[r]  = d;
        req_qstrb_i[r]  = 4'hf;
    endtask

    task automatic rsp(logic [2:0] m, logic [31:0] d);
        data_pvalid_i = 1'b1;
        data_pid_i    = m;
        data_pdata_i  = d;
    endtask

    task automatic push_q(int r, logic w, logic [31:0] a, logic [31:0] d, logic [2:0] m);
        qexp.push_back('{r: r, w: w, a: a, d: d, m: m});
    endtask

    task automatic push_p(int r, logic [31:0] d, logic [2:0] p);
        pexp.push_back('{r: r, d: d, p: p});
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (data_qvalid_o && data_qready_i) begin
                if (qexp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_unexpected: got addr %0h with no expected request", data_qaddr_o);
                end else begin
                    qe = qexp.pop_front();
                    chk("req_grant", 64'(req_qready_o), 64'(1 << qe.r));
                    chk("req_payload", {data_qwrite_o, data_qaddr_o, data_qid_o}, {qe.w, qe.a, qe.m});
                    if (qe.w) chk("req_wdata", 64'(data_qdata_o), 64'(qe.d));
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_pvalid_o[i] && req_pready_i[i]) begin
                    if (pexp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got response on requester %0d", i);
                    end else begin
                        pe = pexp.pop_front();
                        chk("rsp_route", 64'(i), 64'(pe.r));
                        chk("rsp_data_pid", {req_pid_o[i], req_pdata_o[i]}, {pe.p, pe.d});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        req_qaddr_i = '0; req_qwrite_i = '0; req_qamo_i = '0; req_qdata_i = '0;
        req_qstrb_i = '0; req_qid_i = '0; req_qlrwait_i = '0; req_qvalid_i = '0;
        req_pready_i = '0; data_qready_i = 1'b0; data_pdata_i = '0; data_perror_i = 1'b0;
        data_pid_i = '0; data_plrwait_i = 1'b0; data_pvalid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_qvalid", 64'(data_qvalid_o), 64'd0);
        chk("rst_qready", 64'(req_qready_o), 64'd0);
        chk("rst_pvalid", 64'(req_pvalid_o), 64'd0);
        chk("rst_pready", 64'(data_pready_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // Both requesters read back-to-back: grants alternate, meta IDs count up.
        data_qready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd(0, 32'h1000 + 32'(4 * k), 3'(k));
            rd(1, 32'h2000 + 32'(4 * k), 3'(k + 4));
            push_q(k % 2, 1'b0, (k % 2 == 1) ? 32'h2000 + 32'(4 * k) : 32'h1000 + 32'(4 * k), 32'h0, 3'(k));
            step();
        end
        req_qvalid_i = '0;
        data_qready_i = 1'b0;

        // Out-of-order responses: meta 3 then 0, then drain 1 and 2.
        req_pready_i = 2'b11;
        rsp(3, 32'hD3); push_p(1, 32'hD3, 3'd7); step();
        rsp(0, 32'hD0); push_p(0, 32'hD0, 3'd0); step();
        rsp(1, 32'hD1); push_p(1, 32'hD1, 3'd5); step();
        rsp(2, 32'hD2); push_p(0, 32'hD2, 3'd2); step();
        data_pvalid_i = 1'b0;

        // A write from req0 moves rr_ptr to 1 so the following lock actually matters.
        data_qready_i = 1'b1;
        wr(0, 32'h3ffc, 32'h55); push_q(0, 1'b1, 32'h3ffc, 32'h55, 3'd0); step();
        data_qready_i = 1'b0;

        rd(0, 32'h3000, 3'd5);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) rd(1, 32'h4000, 3'd6);
            @(negedge clk_i);
            chk("lock_qvalid", 64'(data_qvalid_o), 64'd1);
            chk("lock_addr", 64'(data_qaddr_o), 64'h3000);
            chk("lock_qid", 64'(data_qid_o), 64'd0);
            chk("lock_qready", 64'(req_qready_o), 64'd0);
            step();
        end
        data_qready_i = 1'b1;
        push_q(0, 1'b0, 32'h3000, 32'h0, 3'd0); step();
        req_qvalid_i[0] = 1'b0;
        push_q(1, 1'b0, 32'h4000, 32'h0, 3'd1); step();
        req_qvalid_i = '0;
        data_qready_i = 1'b0;

        // Response to req1 held back by its pready for two cycles.
        req_pready_i = 2'b01;
        rsp(1, 32'hE1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("hold_pready", 64'(data_pready_o), 64'd0);
            chk("hold_pvalid", 64'(req_pvalid_o), 64'b10);
            chk("hold_pid", 64'(req_pid_o[1]), 64'd6);
            step();
        end
        req_pready_i = 2'b11;
        push_p(1, 32'hE1, 3'd6); step();
        rsp(0, 32'hE0); push_p(0, 32'hE0, 3'd5); step();
        data_pvalid_i = 1'b0;

        // Fill the table from req0.
        data_qready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd(0, 32'h5000 + 32'(4 * k), 3'(k));
            push_q(0, 1'b0, 32'h5000 + 32'(4 * k), 32'h0, 3'(k));
            step();
        end
        rd(0, 32'h7000, 3'd3);
        wr(1, 32'h6000, 32'hAA);
        push_q(1, 1'b1, 32'h6000, 32'hAA, 3'd0);
        @(negedge clk_i);
        chk("full_read_not_ready", 64'(req_qready_o[0]), 64'd0);
        step();
        req_qvalid_i[1] = 1'b0;
        @(negedge clk_i);
        chk("full_no_offer", 64'(data_qvalid_o), 64'd0);
        chk("full_no_ready", 64'(req_qready_o), 64'd0);
        step();
        rsp(2, 32'hF2); push_p(0, 32'hF2, 3'd2);
        @(negedge clk_i);
        chk("full_free_same_cycle", 64'(data_qvalid_o), 64'd0);
        step();
        data_pvalid_i = 1'b0;
        push_q(0, 1'b0, 32'h7000, 32'h0, 3'd2);
        @(negedge clk_i);
        chk("reuse_qid", 64'(data_qid_o), 64'd2);
        step();
        req_qvalid_i = '0;
        data_qready_i = 1'b0;

        for (int k = 0; k < 8; k++) begin
            rsp(3'(k), 32'hC0 + 32'(k));
            push_p(0, 32'hC0 + 32'(k), (k == 2) ? 3'd3 : 3'(k));
            step();
        end
        data_pvalid_i = 1'b0;
        step();
        step();
        chk("req_queue_drained", 64'(qexp.size()), 64'd0);
        chk("rsp_queue_drained", 64'(pexp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
